// File: rtl/tick_scheduler_pkg.sv
// Shared definitions for the tick scheduler.
//   SEL_W            : width of the divide-select field (cfg_sel and each
//                      channel's stored select)
//   ST_IDLE/APPLY/ALIGN : configuration FSM state encodings
package tick_scheduler_pkg;

  localparam int SEL_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_ALIGN = 2'd2;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: holds its enable and divide select and produces a
// registered single-cycle strobe on every rising edge of time-base bit sel.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   cnt        : shared free-running time-base counter
//   apply      : this cycle is APPLY for this channel (disable, load sel)
//   apply_sel  : select value loaded on apply
//   arm        : set the enable on this edge (end of ALIGN)
//   tick       : registered strobe
//   aligned    : cnt[sel:0] == 0 using the currently stored sel
module tick_channel
  import tick_scheduler_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             apply,
  input  logic [SEL_W-1:0] apply_sel,
  input  logic             arm,
  output logic             tick,
  output logic             aligned
);

  logic             en;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] edge_pat;
  logic [CNT_W-1:0] low_mask;
  logic [CNT_W-1:0] low_bits;

  // edge_pat = {1'b1, sel zeros}; low_mask covers bits sel..0. Only legal
  // selects (<= CNT_W-2) are ever stored, so neither shift overflows.
  assign edge_pat = CNT_W'(1) << sel;
  assign low_mask = (edge_pat << 1) - CNT_W'(1);
  assign low_bits = cnt & low_mask;
  assign aligned  = (low_bits == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en   <= 1'b0;
      sel  <= '0;
      tick <= 1'b0;
    end else begin
      // The enable is only cleared at the end of APPLY, so an edge that
      // falls in the APPLY cycle itself must be masked here.
      tick <= en && !apply && (low_bits == edge_pat);
      if (apply) begin
        en  <= 1'b0;
        sel <= apply_sel;
      end else if (arm) begin
        en <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: a free-running time-base counter and
// NUM_CH channels, each strobing once per 2^(sel+1) cycles, reconfigured
// one at a time through a valid/ready request port.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   cfg_valid/ready  : request handshake
//   cfg_ch/sel/en    : target channel, divide select, enable
//   cfg_err          : one-cycle pulse after a request with an illegal select
//   tick_o           : per-channel registered strobes
//   cnt_o            : time-base counter value
//   state            : configuration FSM state (ST_IDLE/ST_APPLY/ST_ALIGN)
//
// Handshake: a request transfers on the rising edge where cfg_valid and
// cfg_ready are both 1; cfg_ch/cfg_sel/cfg_en are captured on that edge.
// cfg_ready depends only on the FSM state, never on cfg_valid, and there
// is no request queue: a held request is taken in the first IDLE cycle.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic              cfg_en,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [1:0]        state
);

  logic [CNT_W-1:0]  cnt;
  logic [1:0]        st;
  logic [CH_W-1:0]   tgt_ch;
  logic [SEL_W-1:0]  tgt_sel;
  logic              tgt_en;
  logic [NUM_CH-1:0] aligned;
  logic [NUM_CH-1:0] apply_v;
  logic [NUM_CH-1:0] arm_v;
  logic              xfer;
  logic              sel_ok;

  assign cfg_ready = (st == ST_IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign sel_ok    = (32'(cfg_sel) <= 32'(CNT_W - 2));
  assign cnt_o     = cnt;
  assign state     = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= ST_IDLE;
      tgt_ch  <= '0;
      tgt_sel <= '0;
      tgt_en  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (xfer) begin
            if (sel_ok) begin
              tgt_ch  <= cfg_ch;
              tgt_sel <= cfg_sel;
              tgt_en  <= cfg_en;
              st      <= ST_APPLY;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_APPLY: st <= tgt_en ? ST_ALIGN : ST_IDLE;
        ST_ALIGN: begin
          if (aligned[tgt_ch]) st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign apply_v[i] = (st == ST_APPLY) && (tgt_ch == CH_W'(i));
    // Enable is set on the edge where the new select's low bits read zero,
    // so the channel starts exactly half a period before its first edge.
    assign arm_v[i]   = (st == ST_ALIGN) && (tgt_ch == CH_W'(i)) && aligned[i];

    tick_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .cnt       (cnt),
      .apply     (apply_v[i]),
      .apply_sel (tgt_sel),
      .arm       (arm_v[i]),
      .tick      (tick_o[i]),
      .aligned   (aligned[i])
    );
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent tick channels.
REQ-002 Parameter CNT_W, default 32, width of the shared free-running time-base counter.
REQ-003 Port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 Port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 Port cfg_valid, input, 1 bit, configuration request valid.
REQ-006 Port cfg_ready, output, 1 bit, scheduler accepts a configuration request this cycle.
REQ-007 Port cfg_ch, input, $clog2(NUM_CH) bits, target channel index.
REQ-008 Port cfg_sel, input, 5 bits, divide select; legal range 0..CNT_W-2; tick period is 2^(cfg_sel+1) cycles.
REQ-009 Port cfg_en, input, 1 bit, 1 = enable the channel, 0 = disable the channel.
REQ-010 Port cfg_err, output, 1 bit, one-cycle pulse marking a rejected request.
REQ-011 Port tick_o, output, NUM_CH bits, per-channel single-cycle strobes, registered.
REQ-012 Port cnt_o, output, CNT_W bits, current time-base counter value.

Function
REQ-013 The scheduler SHALL increment the counter cnt by 1 every cycle and wrap from all-ones to 0 with no gap.
REQ-014 The scheduler SHALL assert tick_o[c] in cycle k+1 when channel c is enabled and cnt[sel_c:0] == {1'b1, sel_c zeros} in cycle k, which is the rising edge of counter bit sel_c.
REQ-015 The tick condition SHALL stay periodic across counter wrap-around, with no missed or extra ticks.
REQ-016 A disabled channel SHALL drive tick_o[c] = 0.
REQ-017 The configuration FSM SHALL have three states: IDLE, APPLY and ALIGN.
REQ-018 cfg_ready SHALL be 1 only in IDLE.
REQ-019 A transfer SHALL occur when cfg_valid and cfg_ready are both 1; cfg_ch, cfg_sel and cfg_en SHALL be captured on that edge.
REQ-020 IDLE SHALL go to APPLY on a transfer with a legal cfg_sel.
REQ-021 A transfer with cfg_sel > CNT_W-2 SHALL pulse cfg_err for exactly 1 cycle, remain in IDLE, and leave all channel state unchanged.
REQ-022 APPLY SHALL last exactly 1 cycle; it SHALL clear the target channel's enable, write sel_c, and suppress any tick of that channel whose edge falls in that cycle.
REQ-023 APPLY SHALL go to ALIGN if the captured enable is 1, and to IDLE otherwise.
REQ-024 ALIGN SHALL wait until cnt[sel_c:0] == 0, then set the target channel's enable on that edge and return to IDLE.
REQ-025 After ALIGN, the channel's first tick SHALL appear exactly 2^sel_c + 1 cycles after the aligning edge, and every later tick SHALL follow every 2^(sel_c+1) cycles.
REQ-026 Channels that are not targeted SHALL keep ticking undisturbed throughout APPLY and ALIGN.
REQ-027 A request to a channel that is already enabled SHALL re-run APPLY/ALIGN, so there is no tick from the moment the request is accepted until the channel is re-aligned.
REQ-028 Two or more channels MAY tick in the same cycle; there is no arbitration between tick outputs.
REQ-029 cfg_valid held high through a busy period SHALL be accepted in the first IDLE cycle; there is no request queue.

Reset
REQ-030 While rst = 1, the block SHALL hold cnt = 0, all enables = 0, all sel = 0, tick_o = 0, cfg_err = 0 and state = IDLE.
REQ-031 cfg_ready SHALL read 1 during reset and on the first cycle after reset.
REQ-032 Reset asserted during APPLY or ALIGN SHALL abort the request with no channel left enabled.
REQ-033 After reset release, cnt SHALL count 0, 1, 2, ... from the first clk edge.

Structure
REQ-034 A shared package SHALL hold the FSM state enumeration (IDLE, APPLY, ALIGN) and the 5-bit select width constant.
REQ-035 The per-channel enable, select and tick-detect logic SHALL be one sub-module, tick_channel, instantiated NUM_CH times by a generate loop.
REQ-036 The counter and the FSM SHALL reside in the top module.

Verification
REQ-037 Scenario: after reset, write ch0 sel=0 en=1 -> tick_o[0] pulses every 2 cycles, and the first pulse is 2 cycles after the aligning edge.
REQ-038 Scenario: write ch1 sel=3 en=1 while ch0 runs at sel=0 -> ch1 ticks every 16 cycles, and ch0 keeps its 2-cycle cadence with no missed pulse.
REQ-039 Scenario: write cfg_sel=31 with CNT_W=32 -> cfg_err is 1 for 1 cycle, no channel state changes, and cfg_ready stays 1.
REQ-040 Scenario: force cnt near 0xFFFFFFF0 with ch2 sel=2 enabled -> tick period stays 8 cycles across the wrap.
REQ-041 Scenario: assert rst during ALIGN for ch3 sel=5 -> all tick_o = 0 after release, ch3 is disabled, and cnt_o = 0.
REQ-042 Scenario: hold cfg_valid high for ch0 then ch1 back-to-back -> the second request is accepted only after the FSM returns to IDLE, and cfg_ready is 0 in between.
